// File: rtl/softmax_pkg.sv
// Shared constants, state encoding and output scaling for the softmax normaliser.
// SOFTMAX_ROUND_EN selects round-half-up scaling instead of truncation.
package softmax_pkg;

  localparam int MAX_LEN  = 64;
  localparam int DATA_W   = 18;
  localparam int RECIP_W  = 36;
  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 15;
  localparam int SHIFT    = RECIP_W - OUT_FRAC;
  localparam int IDX_W    = $clog2(MAX_LEN);
  localparam int CNT_W    = IDX_W + 1;
  localparam int PROD_W   = DATA_W + RECIP_W + 1;
  localparam int RES_W    = PROD_W - SHIFT;

  localparam logic [DATA_W-1:0] SUM_MAX = '1;
  localparam logic [RES_W-1:0]  RES_LIM = RES_W'((1 << OUT_W) - 1);
  localparam logic [PROD_W-1:0] HALF    = PROD_W'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RECIP,
    S_NORM
  } state_e;

  function automatic logic [OUT_W-1:0] scale(
    input logic [DATA_W-1:0]  d,
    input logic [RECIP_W-1:0] r
  );
    logic [PROD_W-1:0] prod;
    logic [RES_W-1:0]  res;
    prod = PROD_W'(d) * PROD_W'(r);
`ifdef SOFTMAX_ROUND_EN
    prod = prod + HALF;
`endif
    res = prod[PROD_W-1:SHIFT];
    return (res > RES_LIM) ? '1 : res[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/softmax_row_buf.sv
// One-row element store for the softmax normaliser.
// Single write port, asynchronous read port.
module softmax_row_buf
  import softmax_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax row normaliser: buffer row, sum, latch reciprocal, stream Q1.15.
// SOFTMAX_ROUND_EN selects rounding of the scaled output.
module softmax_normalizer
  import softmax_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  input  logic               i_in_last,
  output logic [DATA_W-1:0]  o_sum,
  input  logic [RECIP_W-1:0] i_recip,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [OUT_W-1:0]   o_out_data,
  output logic               o_out_last,
  output logic               o_sat
);

  state_e state, nxt;

  logic               row_start;
  logic [CNT_W-1:0]   wr_idx;
  logic [CNT_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  sum;
  logic [RECIP_W-1:0] recip_q;
  logic [RECIP_W-1:0] recip_eff;
  logic [DATA_W-1:0]  rd_data;
  logic [IDX_W-1:0]   widx;
  logic [DATA_W:0]    acc;
  logic               in_fire;
  logic               row_end;
  logic               out_fire;
  logic               more;
  logic               load;

  assign in_fire  = i_in_valid & o_in_ready & (state == S_LOAD);
  assign widx     = row_start ? '0 : wr_idx[IDX_W-1:0];
  assign row_end  = in_fire &
                    (i_in_last | (widx == IDX_W'(MAX_LEN - 1)));
  assign acc      = {1'b0, row_start ? '0 : sum} + {1'b0, i_in_data};
  assign out_fire = o_out_valid & i_out_ready;
  assign more     = rd_idx < wr_idx;
  assign load     = ((state == S_RECIP) | (state == S_NORM)) &
                    (~o_out_valid | i_out_ready) & more;

  // First element is scaled in S_RECIP straight from the reciprocal input.
  assign recip_eff = (state != S_RECIP) ? recip_q :
                     (sum == '0) ? '0 : i_recip;

  assign o_sum = sum;

  softmax_row_buf u_buf (
    .clk   (i_clk),
    .we    (in_fire),
    .waddr (widx),
    .wdata (i_in_data),
    .raddr (rd_idx[IDX_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_LOAD;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_LOAD:  if (row_end) nxt = S_RECIP;
      S_RECIP: nxt = S_NORM;
      S_NORM:  if (out_fire & o_out_last) nxt = S_LOAD;
      default: nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_in_ready  <= 1'b0;
      row_start   <= 1'b1;
      wr_idx      <= '0;
      rd_idx      <= '0;
      sum         <= '0;
      o_sat       <= 1'b0;
      recip_q     <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_last  <= 1'b0;
    end else begin
      o_in_ready <= (nxt == S_LOAD);
      if (in_fire) begin
        row_start <= 1'b0;
        wr_idx    <= CNT_W'(widx) + CNT_W'(1);
        sum       <= acc[DATA_W] ? SUM_MAX : acc[DATA_W-1:0];
        o_sat     <= (~row_start & o_sat) | acc[DATA_W];
      end
      if (state == S_RECIP) recip_q <= recip_eff;
      if (state == S_LOAD) rd_idx <= '0;
      if (load) begin
        o_out_valid <= 1'b1;
        o_out_data  <= scale(rd_data, recip_eff);
        o_out_last  <= (rd_idx == wr_idx - CNT_W'(1));
        rd_idx      <= rd_idx + CNT_W'(1);
      end else if (out_fire) begin
        o_out_valid <= 1'b0;
      end
      if ((state == S_NORM) && (nxt == S_LOAD)) row_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Scoreboard bench for softmax_normalizer with a behavioural reciprocal.
// Honours SOFTMAX_ROUND_EN for expected values.
module tb_softmax_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        in_last;
  logic [17:0] sum;
  logic [35:0] recip;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        sat;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        expq[$];
  int          row[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          last_fire_cyc = 0;
  logic [17:0] exp_sum;
  logic        exp_sat;

  softmax_normalizer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_sum       (sum),
    .i_recip     (recip),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_sat       (sat)
  );

  // Reciprocal contract: floor((2^36-1)/x)
  always_comb begin
    longint unsigned q;
    q = 0;
    if (sum != 0) q = 64'h0000_000F_FFFF_FFFF / {46'd0, sum};
    recip = (sum == 0) ? '1 : q[35:0];
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] model(input longint d, input longint s);
    longint unsigned r, p, q;
    r = (s == 0) ? 0 : 64'h0000_000F_FFFF_FFFF / s;
    p = d * r;
`ifdef SOFTMAX_ROUND_EN
    p = p + (64'd1 << 20);
`endif
    q = p >> 21;
    return (q > 65535) ? 16'hFFFF : q[15:0];
  endfunction

  task automatic send_row(input bit nolast);
    longint s;
    bit     st;
    int     n;
    int     w;
    exp_t   e;
    s = 0;
    st = 0;
    n = row.size();
    foreach (row[i]) begin
      s += row[i];
      if (s > 262143) begin
        s = 262143;
        st = 1;
      end
    end
    exp_sum = s[17:0];
    exp_sat = st;
    foreach (row[i]) begin
      e.d = model(row[i], s);
      e.l = (i == n - 1);
      expq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = 18'(row[i]);
      in_last  = (i == n - 1) && !nolast;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout elem=%0d got=0 want=1", i);
        in_valid = 0;
        return;
      end
      last_fire_cyc = cyc_cnt;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic collect(input bit chk_lat, input int stall_at,
                         input int stall_len);
    int          cyc;
    int          nvalid;
    bit          done;
    bit          first;
    bit          hold_chk;
    logic [15:0] held;
    exp_t        e;
    cyc = 0;
    nvalid = 0;
    done = 0;
    first = 1;
    hold_chk = 0;
    held = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hold_chk) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL hold got v=%b d=%h want v=1 d=%h",
                   out_valid, out_data, held);
        end
      end
      if (out_valid) begin
        nvalid++;
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL in_ready_norm got=%b want=0", in_ready);
        end
        if (first) begin
          first = 0;
          total += 2;
          if (sum !== exp_sum) begin
            bad++;
            $display("FAIL o_sum got=%h want=%h", sum, exp_sum);
          end
          if (sat !== exp_sat) begin
            bad++;
            $display("FAIL o_sat got=%b want=%b", sat, exp_sat);
          end
          if (chk_lat) begin
            total++;
            if (cyc_cnt - last_fire_cyc != 2) begin
              bad++;
              $display("FAIL latency got=%0d want=2",
                       cyc_cnt - last_fire_cyc);
            end
          end
        end
      end
      out_ready = !(stall_at >= 0 && nvalid > stall_at &&
                    nvalid <= stall_at + stall_len);
      if (out_valid && out_ready) begin
        hold_chk = 0;
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL extra_output got=%h want=none", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            bad++;
            $display("FAIL output got d=%h l=%b want d=%h l=%b",
                     out_data, out_last, e.d, e.l);
          end
          if (e.l) done = 1;
        end
      end else if (out_valid) begin
        hold_chk = 1;
        held = out_data;
      end else begin
        hold_chk = 0;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL out_timeout got=none want=last");
    end
    @(negedge clk);
    out_ready = 0;
    total += 3;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_after got=%b want=1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_after got=%b want=0", out_valid);
    end
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL queue_left got=%0d want=0", expq.size());
    end
    expq.delete();
  endtask

  task automatic test_reset;
    rst = 1;
    in_valid = 0;
    in_data = 0;
    in_last = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    total += 4;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready got=%b want=0", in_ready);
    end
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    if (sum !== 18'd0) begin
      bad++;
      $display("FAIL rst_sum got=%h want=0", sum);
    end
    if (sat !== 1'b0) begin
      bad++;
      $display("FAIL rst_sat got=%b want=0", sat);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_single;
    int w;
    logic [15:0] want;
`ifdef SOFTMAX_ROUND_EN
    want = 16'h8000;
`else
    want = 16'h7FFF;
`endif
    row = '{11};
    send_row(0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    total += 4;
    if (cyc_cnt - last_fire_cyc != 2) begin
      bad++;
      $display("FAIL single_latency got=%0d want=2",
               cyc_cnt - last_fire_cyc);
    end
    if (recip !== 36'd6247225157) begin
      bad++;
      $display("FAIL single_recip got=%0d want=6247225157", recip);
    end
    if (out_data !== want) begin
      bad++;
      $display("FAIL single_data got=%h want=%h", out_data, want);
    end
    if (out_last !== 1'b1) begin
      bad++;
      $display("FAIL single_last got=%b want=1", out_last);
    end
    collect(0, -1, 0);
  endtask

  task automatic test_pair;
    row = '{1, 1};
    send_row(0);
    collect(1, -1, 0);
  endtask

  task automatic test_saturate;
    row.delete();
    for (int i = 0; i < 64; i++) row.push_back(18'h3FFFF);
    send_row(1);
    collect(1, -1, 0);
  endtask

  task automatic test_zero;
    row = '{0, 0, 0};
    send_row(0);
    collect(1, -1, 0);
  endtask

  task automatic test_backpressure;
    row = '{3, 1};
    send_row(0);
    collect(1, 1, 5);
  endtask

  task automatic test_mid_reset;
    int w;
    row = '{5, 5, 5};
    send_row(0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    rst = 1;
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_valid got=%b want=0", out_valid);
    end
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_in_ready got=%b want=0", in_ready);
    end
    expq.delete();
    @(negedge clk);
    rst = 0;
    row = '{2};
    send_row(0);
    collect(1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_saturate();
    test_zero();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
